multicycle_maindec: RTL and testbench
=====================================

# multicycle_maindec

Main control FSM for the multicycle MIPS datapath. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles. Instruction and data memory accesses use a `mem_req`/`mem_ready` handshake with a wait-timeout. The block also counts retired instructions and traps illegal opcodes and memory timeouts into a sticky fault state. It sits between the instruction register (`op` comes from the IR output) and the multicycle datapath muxes and enables.

## Interface
- `TIMEOUT`, 16: consecutive `mem_ready`-low cycles in one wait state before a timeout fault; 0 disables the timeout.
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: opcode from the IR, stable outside FETCH.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access requested.
- `iord` out 1: address mux select; 0 = PC, 1 = ALUOut.
- `memwrite` out 1: write strobe.
- `irwrite` out 1: IR load enable.
- `pcwrite` out 1: unconditional PC write.
- `branch` out 1: conditional PC write.
- `ne` out 1: branch on not-equal.
- `regwrite` out 1: register file write.
- `regdst` out 1: write-register select; 1 = rd.
- `memtoreg` out 1: writeback select; 1 = data register.
- `alusrca` out 1: ALU A select; 0 = PC, 1 = rs.
- `alusrcb` out 2: ALU B select; 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2.
- `zeroext` out 1: immediate is zero-extended.
- `pcsrc` out 2: PC source; 00 = ALU, 01 = ALUOut, 10 = jump.
- `aluop` out 2: 00 = add, 01 = sub, 10 = funct, 11 = or.
- `instret` out CNT_W: retired-instruction count, wraps.
- `fault` out 1: sticky fault.
- `fault_cause` out 2: 01 = illegal op, 10 = timeout.

## Operation
- Outputs are decoded from the state; any output not listed for a state is 0.
- **FETCH**
  - Drives `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00.
  - `irwrite`=`pcwrite`=1 only in the cycle `mem_ready`=1; that cycle moves to DECODE.
- **DECODE**
  - Drives `alusrcb`=11, `aluop`=00 (branch target).
  - Next state by opcode: 100011/101011 → MEMADR; 000000 → EXEC; 000100 → BEQEX; 000101 → BNEEX; 001000 → ADDIEX; 001101 → ORIEX; 000010 → JEX; anything else → ERROR with cause 01.
- **MEMADR**: `alusrca`=1, `alusrcb`=10; goes to MEMRD if `op`=100011, else MEMWR.
- **MEMRD**: `mem_req`=1, `iord`=1; moves to MEMWB on `mem_ready`.
- **MEMWB**: `regwrite`=1, `memtoreg`=1, `regdst`=0; then FETCH.
- **MEMWR**: `mem_req`=`iord`=`memwrite`=1 every cycle until `mem_ready`; then FETCH.
- **EXEC**: `alusrca`=1, `alusrcb`=00, `aluop`=10; then ALUWB.
- **ALUWB**: `regwrite`=`regdst`=1; then FETCH.
- **BEQEX**: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1; then FETCH.
- **BNEEX**: same as BEQEX plus `ne`=1.
- **ADDIEX**: `alusrca`=1, `alusrcb`=10, `aluop`=00; then IMMWB.
- **ORIEX**: same as ADDIEX but `aluop`=11, `zeroext`=1; then IMMWB.
- **IMMWB**: `regwrite`=1, `regdst`=0, `memtoreg`=0; then FETCH.
- **JEX**: `pcsrc`=10, `pcwrite`=1; then FETCH.
- **ERROR**
  - All control outputs 0; `fault`=1 and `fault_cause` held.
  - Exits only on `reset`.
- **Wait counter**
  - Counts cycles with `mem_ready`=0 in FETCH, MEMRD or MEMWR, and clears on any state change.
  - When the count reaches `TIMEOUT` with `mem_ready` still 0, the next state is ERROR with cause 10.
  - If `mem_ready`=1 on that same cycle, `mem_ready` wins and no fault is raised.
- **Retired-instruction counter**: `instret` increments by 1 on every transition into FETCH from a state other than FETCH; it wraps modulo 2^CNT_W.

## Timing
- `reset`=1 at a clock edge sets: state = FETCH, `instret`=0, `fault`=0, `fault_cause`=00, wait counter = 0.
- While `reset` is high, all strobes (`mem_req`, `irwrite`, `pcwrite`, `memwrite`, `regwrite`, `branch`) are forced to 0.
- A reset mid-instruction aborts it without counting it.
- Latency with zero-wait memory (`mem_ready` always 1), in cycles:
  - LW 5; SW 4; R-type 4; ADDI 4; ORI 4; BEQ/BNE 3; J 3.
  - Each wait cycle adds 1.
- The handshake completes in the cycle where `mem_req` and `mem_ready` are both 1. `mem_ready` while `mem_req`=0 is ignored.

## Configuration
- `MULTICYCLE_MAINDEC_BNE_EN` defined: opcode 000101 decodes to BNEEX.
- Not defined: BNEEX is not built, `ne` is tied to 0, and 000101 goes to ERROR with cause 01.

## Test plan
- Reset, then LW (`op`=100011) with `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB, then back to FETCH. `regwrite`=`memtoreg`=1 in the 5th cycle; `instret`=1.
- SW with `mem_ready` low for 3 cycles in MEMWR → `memwrite`=1 for 4 cycles, then FETCH; total latency 7; `instret` +1.
- `op`=000101 → with the macro: `branch`=`ne`=1 in cycle 3. Without the macro: `fault`=1, `fault_cause`=01, all strobes 0 until reset.
- `TIMEOUT`=4, `mem_ready` held 0 in FETCH → ERROR after 4 wait cycles, `fault_cause`=10. With `mem_ready`=1 on the 4th cycle → DECODE and no fault.
- `CNT_W`=4, 16 back-to-back J instructions → `instret` returns to 0; `pcwrite`=1 with `pcsrc`=10 in each JEX.
- Reset asserted during MEMRD → next cycle FETCH, `instret` unchanged at 0 and `fault`=0.

Source files
------------

// File: rtl/multicycle_maindec.sv
// multicycle_maindec: main control FSM for the multicycle MIPS datapath.
// It steps each instruction through fetch, decode, execute, memory and
// writeback. Memory accesses use a mem_req/mem_ready handshake with a
// wait timeout. Retired instructions are counted, and illegal opcodes and
// memory timeouts are trapped into a sticky ERROR state.
// Optional feature: define MULTICYCLE_MAINDEC_BNE_EN to build BNE support.
// Without it, opcode 000101 is illegal and ne is tied to 0.
module multicycle_maindec #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             iord,
   output logic             memwrite,
   output logic             irwrite,
   output logic             pcwrite,
   output logic             branch,
   output logic             ne,
   output logic             regwrite,
   output logic             regdst,
   output logic             memtoreg,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic             zeroext,
   output logic [1:0]       pcsrc,
   output logic [1:0]       aluop,
   output logic [CNT_W-1:0] instret,
   output logic             fault,
   output logic [1:0]       fault_cause
);

   localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BEQEX  = 4'd8,
`ifdef MULTICYCLE_MAINDEC_BNE_EN
      S_BNEEX  = 4'd9,
`endif
      S_ADDIEX = 4'd10,
      S_ORIEX  = 4'd11,
      S_IMMWB  = 4'd12,
      S_JEX    = 4'd13,
      S_ERROR  = 4'd14
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                wait_state;
   logic                timeout_hit;
   logic [1:0]          enter_cause;

   assign wait_state  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
   assign timeout_hit = (TIMEOUT != 0) && wait_state && !mem_ready &&
                        (wait_cnt == WAIT_W'(TIMEOUT - 1));

   // Next-state selection. In a wait state, mem_ready beats a timeout that
   // lands on the same cycle.
   always_comb begin
      next_state  = state;
      enter_cause = CAUSE_ILLEGAL;
      case (state)
         S_FETCH: begin
            if (mem_ready) begin
               next_state = S_DECODE;
            end else if (timeout_hit) begin
               next_state  = S_ERROR;
               enter_cause = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_RTYP:      next_state = S_EXEC;
               OP_BEQ:       next_state = S_BEQEX;
`ifdef MULTICYCLE_MAINDEC_BNE_EN
               OP_BNE:       next_state = S_BNEEX;
`endif
               OP_ADDI:      next_state = S_ADDIEX;
               OP_ORI:       next_state = S_ORIEX;
               OP_J:         next_state = S_JEX;
               default: begin
                  next_state  = S_ERROR;
                  enter_cause = CAUSE_ILLEGAL;
               end
            endcase
         end
         S_MEMADR: next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD, S_MEMWR: begin
            if (mem_ready) begin
               next_state = (state == S_MEMRD) ? S_MEMWB : S_FETCH;
            end else if (timeout_hit) begin
               next_state  = S_ERROR;
               enter_cause = CAUSE_TIMEOUT;
            end
         end
         S_MEMWB:  next_state = S_FETCH;
         S_EXEC:   next_state = S_ALUWB;
         S_ALUWB:  next_state = S_FETCH;
         S_BEQEX:  next_state = S_FETCH;
`ifdef MULTICYCLE_MAINDEC_BNE_EN
         S_BNEEX:  next_state = S_FETCH;
`endif
         S_ADDIEX: next_state = S_IMMWB;
         S_ORIEX:  next_state = S_IMMWB;
         S_IMMWB:  next_state = S_FETCH;
         S_JEX:    next_state = S_FETCH;
         default:  next_state = S_ERROR;
      endcase
   end

   // State, wait counter, retired count and sticky fault. A reset aborts
   // the current instruction without counting it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_FETCH;
         wait_cnt    <= '0;
         instret     <= '0;
         fault       <= 1'b0;
         fault_cause <= 2'b00;
      end else begin
         state <= next_state;
         if (next_state != state) begin
            wait_cnt <= '0;
         end else if (wait_state && !mem_ready && (TIMEOUT != 0)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
         if ((next_state == S_FETCH) && (state != S_FETCH)) begin
            instret <= instret + CNT_W'(1);
         end
         if ((next_state == S_ERROR) && (state != S_ERROR)) begin
            fault       <= 1'b1;
            fault_cause <= enter_cause;
         end
      end
   end

   // Datapath controls decoded from the state. Strobes are held low while
   // reset is asserted.
   always_comb begin
      mem_req  = 1'b0;
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
`ifdef MULTICYCLE_MAINDEC_BNE_EN
      ne       = 1'b0;
`endif
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      zeroext  = 1'b0;
      pcsrc    = 2'b00;
      aluop    = 2'b00;
      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcwrite = mem_ready;
         end
         S_DECODE: alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
`ifdef MULTICYCLE_MAINDEC_BNE_EN
         S_BNEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
            ne      = 1'b1;
         end
`endif
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ORIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            aluop   = 2'b11;
            zeroext = 1'b1;
         end
         S_IMMWB: regwrite = 1'b1;
         S_JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         mem_req  = 1'b0;
         irwrite  = 1'b0;
         pcwrite  = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
         branch   = 1'b0;
      end
   end

`ifndef MULTICYCLE_MAINDEC_BNE_EN
   assign ne = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_maindec.sv
// tb_multicycle_maindec: directed, table-driven check of multicycle_maindec
// (TIMEOUT=4, CNT_W=4), plus hand-written timeout, counter-wrap and reset
// sequences.
module tb_multicycle_maindec;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'd0;
   logic       mem_ready = 1'b1;
   logic       mem_req, iord, memwrite, irwrite, pcwrite, branch, ne;
   logic       regwrite, regdst, memtoreg, alusrca, zeroext;
   logic [1:0] alusrcb, pcsrc, aluop;
   logic [3:0] instret;
   logic       fault;
   logic [1:0] fault_cause;

   int checks = 0;
   int failures = 0;

   // Bit order: mem_req iord memwrite irwrite pcwrite branch ne regwrite
   // regdst memtoreg alusrca | alusrcb | zeroext | pcsrc | aluop
   localparam logic [17:0] C_FETCH_RST  = 18'b0_0_0_0_0_0_0_0_0_0_0_01_0_00_00;
   localparam logic [17:0] C_FETCH_RDY  = 18'b1_0_0_1_1_0_0_0_0_0_0_01_0_00_00;
   localparam logic [17:0] C_FETCH_WAIT = 18'b1_0_0_0_0_0_0_0_0_0_0_01_0_00_00;
   localparam logic [17:0] C_DECODE     = 18'b0_0_0_0_0_0_0_0_0_0_0_11_0_00_00;
   localparam logic [17:0] C_MEMADR     = 18'b0_0_0_0_0_0_0_0_0_0_1_10_0_00_00;
   localparam logic [17:0] C_MEMRD      = 18'b1_1_0_0_0_0_0_0_0_0_0_00_0_00_00;
   localparam logic [17:0] C_MEMRD_RST  = 18'b0_1_0_0_0_0_0_0_0_0_0_00_0_00_00;
   localparam logic [17:0] C_MEMWB      = 18'b0_0_0_0_0_0_0_1_0_1_0_00_0_00_00;
   localparam logic [17:0] C_MEMWR      = 18'b1_1_1_0_0_0_0_0_0_0_0_00_0_00_00;
   localparam logic [17:0] C_EXEC       = 18'b0_0_0_0_0_0_0_0_0_0_1_00_0_00_10;
   localparam logic [17:0] C_ALUWB      = 18'b0_0_0_0_0_0_0_1_1_0_0_00_0_00_00;
   localparam logic [17:0] C_BEQEX      = 18'b0_0_0_0_0_1_0_0_0_0_1_00_0_01_01;
   localparam logic [17:0] C_BNEEX      = 18'b0_0_0_0_0_1_1_0_0_0_1_00_0_01_01;
   localparam logic [17:0] C_ADDIEX     = 18'b0_0_0_0_0_0_0_0_0_0_1_10_0_00_00;
   localparam logic [17:0] C_ORIEX      = 18'b0_0_0_0_0_0_0_0_0_0_1_10_1_00_11;
   localparam logic [17:0] C_IMMWB      = 18'b0_0_0_0_0_0_0_1_0_0_0_00_0_00_00;
   localparam logic [17:0] C_JEX        = 18'b0_0_0_0_1_0_0_0_0_0_0_00_0_10_00;
   localparam logic [17:0] C_ERROR      = 18'b0;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef struct {
      logic        rst;
      logic [5:0]  opc;
      logic        rdy;
      logic [17:0] ctl;
      logic [3:0]  ins;
      logic        flt;
      logic [1:0]  cause;
   } vec_t;

   vec_t vecs[$];

   wire [17:0] ctl_act = {mem_req, iord, memwrite, irwrite, pcwrite, branch, ne,
                          regwrite, regdst, memtoreg, alusrca, alusrcb, zeroext,
                          pcsrc, aluop};

   multicycle_maindec #(.TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
      .pcwrite(pcwrite), .branch(branch), .ne(ne), .regwrite(regwrite),
      .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
      .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc), .aluop(aluop),
      .instret(instret), .fault(fault), .fault_cause(fault_cause)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs on the falling edge, then let them settle.
   task automatic applyStimulus(input logic r, input logic [5:0] o, input logic m);
      @(negedge clk);
      reset = r;
      op = o;
      mem_ready = m;
      #1;
   endtask

   // Compare controls, counter and fault against the required values.
   task automatic checkOutput(input string name, input logic [17:0] ctl_exp,
                              input logic [3:0] ins_exp, input logic flt_exp,
                              input logic [1:0] cause_exp);
      checks++;
      if (ctl_act !== ctl_exp) begin
         failures++;
         $display("[TB] FAIL %s ctl: actual=%b required=%b", name, ctl_act, ctl_exp);
      end
      checks++;
      if (instret !== ins_exp) begin
         failures++;
         $display("[TB] FAIL %s instret: actual=%0d required=%0d", name, instret, ins_exp);
      end
      checks++;
      if ({fault, fault_cause} !== {flt_exp, cause_exp}) begin
         failures++;
         $display("[TB] FAIL %s fault/cause: actual=%b/%b required=%b/%b",
                  name, fault, fault_cause, flt_exp, cause_exp);
      end
   endtask

   task automatic addVec(input logic r, input logic [5:0] o, input logic m,
                         input logic [17:0] c, input logic [3:0] i,
                         input logic f, input logic [1:0] ca);
      vec_t v;
      v.rst = r; v.opc = o; v.rdy = m; v.ctl = c; v.ins = i; v.flt = f; v.cause = ca;
      vecs.push_back(v);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 6'd0, 1'b1);
      applyStimulus(1'b1, 6'd0, 1'b1);
      checkOutput("reset", C_FETCH_RST, 4'd0, 1'b0, 2'b00);
   endtask

   initial begin
      // Instruction mix; op is set in FETCH and held for the instruction.
      addVec(1, OP_RTYP, 1, C_FETCH_RST, 0, 0, 2'b00);
      addVec(0, OP_LW, 1, C_FETCH_RDY, 0, 0, 2'b00);
      addVec(0, OP_LW, 1, C_DECODE, 0, 0, 2'b00);
      addVec(0, OP_LW, 1, C_MEMADR, 0, 0, 2'b00);
      addVec(0, OP_LW, 1, C_MEMRD, 0, 0, 2'b00);
      addVec(0, OP_LW, 1, C_MEMWB, 0, 0, 2'b00);
      addVec(0, OP_SW, 1, C_FETCH_RDY, 1, 0, 2'b00);
      addVec(0, OP_SW, 1, C_DECODE, 1, 0, 2'b00);
      addVec(0, OP_SW, 1, C_MEMADR, 1, 0, 2'b00);
      addVec(0, OP_SW, 0, C_MEMWR, 1, 0, 2'b00);
      addVec(0, OP_SW, 0, C_MEMWR, 1, 0, 2'b00);
      addVec(0, OP_SW, 0, C_MEMWR, 1, 0, 2'b00);
      addVec(0, OP_SW, 1, C_MEMWR, 1, 0, 2'b00);
      addVec(0, OP_RTYP, 1, C_FETCH_RDY, 2, 0, 2'b00);
      addVec(0, OP_RTYP, 1, C_DECODE, 2, 0, 2'b00);
      addVec(0, OP_RTYP, 1, C_EXEC, 2, 0, 2'b00);
      addVec(0, OP_RTYP, 1, C_ALUWB, 2, 0, 2'b00);
      addVec(0, OP_ADDI, 1, C_FETCH_RDY, 3, 0, 2'b00);
      addVec(0, OP_ADDI, 1, C_DECODE, 3, 0, 2'b00);
      addVec(0, OP_ADDI, 1, C_ADDIEX, 3, 0, 2'b00);
      addVec(0, OP_ADDI, 1, C_IMMWB, 3, 0, 2'b00);
      addVec(0, OP_ORI, 1, C_FETCH_RDY, 4, 0, 2'b00);
      addVec(0, OP_ORI, 1, C_DECODE, 4, 0, 2'b00);
      addVec(0, OP_ORI, 1, C_ORIEX, 4, 0, 2'b00);
      addVec(0, OP_ORI, 1, C_IMMWB, 4, 0, 2'b00);
      addVec(0, OP_BEQ, 1, C_FETCH_RDY, 5, 0, 2'b00);
      addVec(0, OP_BEQ, 1, C_DECODE, 5, 0, 2'b00);
      addVec(0, OP_BEQ, 1, C_BEQEX, 5, 0, 2'b00);
      // LW with 3 waits in FETCH and 3 in MEMRD: the counter restarts per state.
      addVec(0, OP_LW, 0, C_FETCH_WAIT, 6, 0, 2'b00);
      addVec(0, OP_LW, 0, C_FETCH_WAIT, 6, 0, 2'b00);
      addVec(0, OP_LW, 0, C_FETCH_WAIT, 6, 0, 2'b00);
      addVec(0, OP_LW, 1, C_FETCH_RDY, 6, 0, 2'b00);
      addVec(0, OP_LW, 1, C_DECODE, 6, 0, 2'b00);
      addVec(0, OP_LW, 1, C_MEMADR, 6, 0, 2'b00);
      addVec(0, OP_LW, 0, C_MEMRD, 6, 0, 2'b00);
      addVec(0, OP_LW, 0, C_MEMRD, 6, 0, 2'b00);
      addVec(0, OP_LW, 0, C_MEMRD, 6, 0, 2'b00);
      addVec(0, OP_LW, 1, C_MEMRD, 6, 0, 2'b00);
      addVec(0, OP_LW, 1, C_MEMWB, 6, 0, 2'b00);
      addVec(0, OP_BNE, 1, C_FETCH_RDY, 7, 0, 2'b00);
      addVec(0, OP_BNE, 1, C_DECODE, 7, 0, 2'b00);
`ifdef MULTICYCLE_MAINDEC_BNE_EN
      addVec(0, OP_BNE, 1, C_BNEEX, 7, 0, 2'b00);
      addVec(0, OP_BNE, 1, C_FETCH_RDY, 8, 0, 2'b00);
`else
      addVec(0, OP_BNE, 1, C_ERROR, 7, 1, 2'b01);
      addVec(0, OP_BNE, 1, C_ERROR, 7, 1, 2'b01);
`endif

      applyStimulus(1'b1, 6'd0, 1'b1);
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].opc, vecs[i].rdy);
         checkOutput($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].ins,
                     vecs[i].flt, vecs[i].cause);
      end

      // Timeout: four low cycles in FETCH go to ERROR with cause 10.
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, OP_J, 1'b0);
         checkOutput("to_wait", C_FETCH_WAIT, 4'd0, 1'b0, 2'b00);
      end
      applyStimulus(1'b0, OP_J, 1'b0);
      checkOutput("to_error", C_ERROR, 4'd0, 1'b1, 2'b10);
      applyStimulus(1'b0, OP_J, 1'b1);
      checkOutput("to_sticky", C_ERROR, 4'd0, 1'b1, 2'b10);

      // mem_ready on the fourth cycle wins over the timeout.
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, OP_J, 1'b0);
      end
      applyStimulus(1'b0, OP_J, 1'b1);
      checkOutput("to_ready4", C_FETCH_RDY, 4'd0, 1'b0, 2'b00);
      applyStimulus(1'b0, OP_J, 1'b1);
      checkOutput("to_decode", C_DECODE, 4'd0, 1'b0, 2'b00);

      // Sixteen back-to-back J instructions wrap the 4-bit counter.
      doReset();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, OP_J, 1'b1);
         checkOutput("j_fetch", C_FETCH_RDY, 4'(i), 1'b0, 2'b00);
         applyStimulus(1'b0, OP_J, 1'b1);
         applyStimulus(1'b0, OP_J, 1'b1);
         checkOutput("j_jex", C_JEX, 4'(i), 1'b0, 2'b00);
      end
      applyStimulus(1'b0, OP_J, 1'b1);
      checkOutput("j_wrap", C_FETCH_RDY, 4'd0, 1'b0, 2'b00);

      // Reset during MEMRD aborts the load without counting it.
      doReset();
      applyStimulus(1'b0, OP_LW, 1'b1);
      applyStimulus(1'b0, OP_LW, 1'b1);
      applyStimulus(1'b0, OP_LW, 1'b1);
      applyStimulus(1'b0, OP_LW, 1'b0);
      checkOutput("rst_memrd", C_MEMRD, 4'd0, 1'b0, 2'b00);
      applyStimulus(1'b1, OP_LW, 1'b1);
      checkOutput("rst_gated", C_MEMRD_RST, 4'd0, 1'b0, 2'b00);
      applyStimulus(1'b0, OP_LW, 1'b0);
      checkOutput("rst_fetch", C_FETCH_WAIT, 4'd0, 1'b0, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
